// File: rtl/prog_clk_div.sv
// prog_clk_div: runtime-programmable clock divider producing a duty-balanced
// divided signal and a one-cycle tick per period. Ratio changes wait for a
// period boundary (or a restart) so the output never glitches.
module prog_clk_div #(
  parameter int unsigned      CNT_W       = 32,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(100000000)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             restart,
  input  logic             div_load,
  input  logic [CNT_W-1:0] div_ratio,
  output logic             div_out,
  output logic             tick,
  output logic [CNT_W-1:0] cur_ratio,
  output logic             load_pend,
  output logic             load_err
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] pending;

  logic [CNT_W-1:0] cnt_nx;
  logic [CNT_W-1:0] ratio_nx;
  logic [CNT_W-1:0] pending_nx;
  logic [CNT_W-1:0] pend_val;
  logic             pend_nx;
  logic             div_nx;
  logic             tick_nx;
  logic             err_nx;
  logic             load_ok;
  logic             have_pend;
  logic             last;
  logic             apply;

  // Next-state: counter advance, ratio hand-over, and output decode of the new count
  always_comb begin
    load_ok   = div_load && (div_ratio != '0);
    // A valid load arriving on the same edge as a boundary/restart bypasses
    // the pending register and is applied directly.
    have_pend = load_ok || load_pend;
    pend_val  = load_ok ? div_ratio : pending;
    last      = (cnt == cur_ratio - CNT_W'(1));

    cnt_nx     = cnt;
    ratio_nx   = cur_ratio;
    pending_nx = load_ok ? div_ratio : pending;
    pend_nx    = have_pend;
    div_nx     = div_out;
    tick_nx    = tick;
    err_nx     = div_load && (div_ratio == '0);
    apply      = 1'b0;

    if (restart) begin
      cnt_nx = '0;
      apply  = have_pend;
    end else if (en) begin
      if (last) begin
        cnt_nx = '0;
        apply  = have_pend;
      end else begin
        cnt_nx = cnt + CNT_W'(1);
      end
    end

    if (apply) begin
      ratio_nx = pend_val;
      pend_nx  = 1'b0;
    end

    // Outputs track the decode of the count being written, using the ratio
    // that will be in effect from this edge on.
    if (restart) begin
      div_nx  = 1'b0;
      tick_nx = 1'b0;
    end else if (en) begin
      div_nx  = (cnt_nx >= (ratio_nx >> 1));
      tick_nx = (cnt_nx == ratio_nx - CNT_W'(1));
    end
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      pending   <= '0;
      cur_ratio <= DEFAULT_DIV;
      load_pend <= 1'b0;
      div_out   <= 1'b0;
      tick      <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      cnt       <= cnt_nx;
      pending   <= pending_nx;
      cur_ratio <= ratio_nx;
      load_pend <= pend_nx;
      div_out   <= div_nx;
      tick      <= tick_nx;
      load_err  <= err_nx;
    end
  end

endmodule

// File: tb/tb_prog_clk_div.sv
// Directed testbench for prog_clk_div with CNT_W=8 and DEFAULT_DIV=4.
// Stimulus rows are {0, en, restart, div_load, div_ratio[7:0]}.
// Expected rows are {div_out, tick, load_pend, load_err, cur_ratio[7:0]}.
module tb_prog_clk_div;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       restart = 1'b0;
  logic       div_load = 1'b0;
  logic [7:0] div_ratio = '0;
  logic       div_out;
  logic       tick;
  logic [7:0] cur_ratio;
  logic       load_pend;
  logic       load_err;

  int n_checks = 0;
  int n_fail   = 0;

  prog_clk_div #(
    .CNT_W      (8),
    .DEFAULT_DIV(8'd4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .restart  (restart),
    .div_load (div_load),
    .div_ratio(div_ratio),
    .div_out  (div_out),
    .tick     (tick),
    .cur_ratio(cur_ratio),
    .load_pend(load_pend),
    .load_err (load_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [11:0] obs();
    return {div_out, tick, load_pend, load_err, cur_ratio};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [11:0] s);
    en        = s[10];
    restart   = s[9];
    div_load  = s[8];
    div_ratio = s[7:0];
  endtask

  task automatic do_reset();
    drive(12'h000);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [11:0] e [8] = '{12'h004, 12'h804, 12'hC04, 12'h004,
                           12'h004, 12'h804, 12'hC04, 12'h004};
    do_reset();
    n_checks++;
    if (obs() !== 12'h004) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", obs(), 12'h004);
    end
    for (int i = 0; i < 8; i++) begin
      drive(12'h400);
      step();
      n_checks++;
      if (obs() !== e[i]) begin
        n_fail++;
        $display("FAIL reset_div4 row %0d: got %h expected %h", i, obs(), e[i]);
      end
    end
  endtask

  task automatic test_load_mid();
    logic [11:0] s [9] = '{12'h400, 12'h505, 12'h400, 12'h400, 12'h400,
                           12'h400, 12'h400, 12'h400, 12'h400};
    logic [11:0] e [9] = '{12'h004, 12'hA04, 12'hE04, 12'h005, 12'h005,
                           12'h805, 12'h805, 12'hC05, 12'h005};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(s[i]);
      step();
      n_checks++;
      if (obs() !== e[i]) begin
        n_fail++;
        $display("FAIL load_mid row %0d: got %h expected %h", i, obs(), e[i]);
      end
    end
  endtask

  task automatic test_last_wins();
    logic [11:0] s [10] = '{12'h507, 12'h503, 12'h400, 12'h400, 12'h400,
                            12'h400, 12'h506, 12'h400, 12'h400, 12'h400};
    logic [11:0] e [10] = '{12'h204, 12'hA04, 12'hE04, 12'h003, 12'h803,
                            12'hC03, 12'h006, 12'h006, 12'h006, 12'h806};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(s[i]);
      step();
      n_checks++;
      if (obs() !== e[i]) begin
        n_fail++;
        $display("FAIL last_wins row %0d: got %h expected %h", i, obs(), e[i]);
      end
    end
  endtask

  task automatic test_zero_load();
    logic [11:0] s [8] = '{12'h400, 12'h500, 12'h400, 12'h400,
                           12'h505, 12'h500, 12'h400, 12'h400};
    logic [11:0] e [8] = '{12'h004, 12'h904, 12'hC04, 12'h004,
                           12'h204, 12'hB04, 12'hE04, 12'h005};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(s[i]);
      step();
      n_checks++;
      if (obs() !== e[i]) begin
        n_fail++;
        $display("FAIL zero_load row %0d: got %h expected %h", i, obs(), e[i]);
      end
    end
  endtask

  task automatic test_freeze();
    logic [11:0] s [18] = '{12'h400, 12'h400,
                            12'h000, 12'h000, 12'h000, 12'h000, 12'h000,
                            12'h000, 12'h000, 12'h000, 12'h000, 12'h000,
                            12'h102, 12'h000, 12'h400, 12'h400, 12'h400, 12'h400};
    logic [11:0] e [18] = '{12'h004, 12'h804,
                            12'h804, 12'h804, 12'h804, 12'h804, 12'h804,
                            12'h804, 12'h804, 12'h804, 12'h804, 12'h804,
                            12'hA04, 12'hA04, 12'hE04, 12'h002, 12'hC02, 12'h002};
    do_reset();
    for (int i = 0; i < 18; i++) begin
      drive(s[i]);
      step();
      n_checks++;
      if (obs() !== e[i]) begin
        n_fail++;
        $display("FAIL freeze row %0d: got %h expected %h", i, obs(), e[i]);
      end
    end
  endtask

  task automatic test_restart();
    logic [11:0] s [12] = '{12'h400, 12'h501, 12'h600, 12'h400, 12'h400, 12'h400,
                            12'h400, 12'h200, 12'h400, 12'h704, 12'h400, 12'h400};
    logic [11:0] e [12] = '{12'h004, 12'hA04, 12'h001, 12'hC01, 12'hC01, 12'hC01,
                            12'hC01, 12'h001, 12'hC01, 12'h004, 12'h004, 12'h804};
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(s[i]);
      step();
      n_checks++;
      if (obs() !== e[i]) begin
        n_fail++;
        $display("FAIL restart row %0d: got %h expected %h", i, obs(), e[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [11:0] e [4] = '{12'h004, 12'h804, 12'hC04, 12'h004};
    do_reset();
    drive(12'h505);
    step();
    n_checks++;
    if (obs() !== 12'h204) begin
      n_fail++;
      $display("FAIL async_pre load: got %h expected %h", obs(), 12'h204);
    end
    drive(12'h400);
    step();
    n_checks++;
    if (obs() !== 12'hA04) begin
      n_fail++;
      $display("FAIL async_pre high: got %h expected %h", obs(), 12'hA04);
    end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (obs() !== 12'h004) begin
      n_fail++;
      $display("FAIL async_mid: got %h expected %h", obs(), 12'h004);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(12'h400);
      step();
      n_checks++;
      if (obs() !== e[i]) begin
        n_fail++;
        $display("FAIL async_post row %0d: got %h expected %h", i, obs(), e[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_mid();
    test_last_wins();
    test_zero_load();
    test_freeze();
    test_restart();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
